operation_i_seq: RTL
====================

Name: operation_i_seq

Overview:
- Parametrised successor to the fixed projection operator (Maltsev operation I).
- Returns input number SEL out of INC inputs, each BW bits wide; SEL is a runtime port, not a build-time constant.
- Uses a serial scan: the latched input vector is shifted one word per cycle. This trades latency for a single BW-wide compare/output path instead of an INC:1 mux.
- Keeps the codebase ST/RD start–ready handshake so it drops into existing operator compositions.

Parameters:
- BW, 16: bit width of each input word and of RES.
- INC, 3: number of inputs (≥2).
- SELW, 2: width of SEL; must satisfy 2^SELW ≥ INC.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous and active-low: sampled on the CLK rising edge, state cleared while RST=0.
- ST  in  1  start; level, sampled only in IDLE.
- SEL  in  SELW  index of the input to return; latched with ST.
- IN  in  BW*INC  flattened inputs; input k = IN[k*BW +: BW]; latched with ST.
- RD  out  1  result ready.
- RES  out  BW  projected value.
- ERR  out  1  out-of-range select; present only with OPERATION_I_SEL_CHECK_EN.

Behaviour:
- Reset (RST=0 at edge): state=IDLE, RD=0, RES=0, cnt=0, shift register=0, ERR=0. A reset mid-SCAN or mid-DONE aborts the operation; no RD pulse follows.
- States:
  - IDLE: if ST=1 at an edge, latch IN into the shift register (word 0 at the head), latch SEL into sel_r, set cnt=0, clear RD, go to SCAN. RES keeps its previous value.
  - SCAN: each edge:
    - if cnt==sel_r: RES<=head, RD<=1, go to DONE;
    - else shift the register down one word (head<=word1, zero fill at the top), cnt<=cnt+1.
  - DONE: RD=1, RES stable. When ST=0 at an edge, go to IDLE and set RD<=0.
- Start rules:
  - A new operation needs ST to return low first. ST held high in DONE does not restart.
  - IN and SEL changes after the latch edge have no effect on the running operation.
- Latency:
  - ST sampled at edge t, so RD=1 and RES valid after edge t+1+SEL.
  - SEL=0 gives RD at t+1; SEL=INC-1 gives RD at t+INC.
- Out of range (SEL ≥ INC), build without the check: the scan runs until cnt==sel_r. Shifted-in zero words mean RES=0, with RD after edge t+1+SEL. cnt is SELW bits wide and never wraps before the match.
- Simultaneous events:
  - RST=0 overrides ST.
  - ST=1 arriving on the same edge as the IDLE transition from DONE is ignored; the next start is sampled one edge later in IDLE.
- RES holds the last result through IDLE until the next DONE entry.

Optional Feature:
- Macro: OPERATION_I_SEL_CHECK_EN.
- Defined:
  - ERR port exists.
  - In IDLE with ST=1 and SEL ≥ INC: go directly to DONE at the next edge with RES<=0, ERR<=1, RD<=1 (latency 1 cycle, no scan).
  - ERR clears on the next accepted start and on reset.
  - In-range operations leave ERR=0.
- Not defined: no ERR port; out-of-range behaves as the scan-to-zero rule above.

Test Plan:
- Reset/basic SEL=2: RST=0 for 2 edges; check RD=0, RES=0. Release RST; IN0=0, IN1=1, IN2=2, SEL=2, ST=1 at edge t -> RD=1 after edge t+3, RES=16'h0002; RD stays 1 while ST=1.
- SEL=0 minimum latency: IN0=16'hBEEF, SEL=0 -> RD after edge t+1, RES=16'hBEEF. Drop ST -> RD=0 after the next edge, RES still 16'hBEEF.
- Input change during scan: start SEL=1 with IN1=16'h0005, then change IN1 to 16'h00AA at t+1 -> RES=16'h0005.
- Back-to-back operations: keep ST high through DONE -> no restart. ST low for 1 edge, then high with SEL=1 -> second result correct, and RD was low for at least 1 cycle between operations.
- Reset mid-scan: BW=16, INC=4, SELW=2, SEL=3; RST=0 at t+2 -> RD never asserts, state IDLE, RES=0.
- Out of range: INC=3, SEL=3. Without the macro -> RD after edge t+4, RES=0. With OPERATION_I_SEL_CHECK_EN -> RD and ERR both 1 after edge t+1, RES=0; a following in-range start clears ERR.

Source files
------------

// File: rtl/operation_i_seq_if.sv
// Start/ready bundle for operation_i_seq: start, select, flattened inputs, ready and result.
// The ERR signal exists only when OPERATION_I_SEL_CHECK_EN is defined.
interface operation_i_seq_if #(
    parameter int BW   = 16,
    parameter int INC  = 3,
    parameter int SELW = 2
);
    // Handshake: the master raises ST with SEL/IN valid; the slave latches them on the
    // first rising edge it sees ST=1 while idle. RD then rises once RES is valid and stays
    // high until ST is seen low. A new start needs ST low for at least one edge after RD.
    logic                ST;
    logic [SELW-1:0]     SEL;
    logic [BW*INC-1:0]   IN;
    logic                RD;
    logic [BW-1:0]       RES;
`ifdef OPERATION_I_SEL_CHECK_EN
    logic                ERR;

    modport master (output ST, SEL, IN, input RD, RES, ERR);
    modport slave  (input ST, SEL, IN, output RD, RES, ERR);
`else
    modport master (output ST, SEL, IN, input RD, RES);
    modport slave  (input ST, SEL, IN, output RD, RES);
`endif
endinterface

// File: rtl/operation_i_seq.sv
// Runtime-selectable projection (Maltsev operation I) using a serial word scan.
// Optional macro OPERATION_I_SEL_CHECK_EN adds ERR and short-circuits out-of-range selects.
module operation_i_seq #(
    parameter int BW   = 16,
    parameter int INC  = 3,
    parameter int SELW = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    operation_i_seq_if.slave         bus,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (INC < 2) begin : g_bad_inc
        $error("operation_i_seq: INC must be at least 2");
    end
    if ((1 << SELW) < INC) begin : g_bad_selw
        $error("operation_i_seq: SELW too narrow for INC");
    end

    state_t              state, state_n;
    logic [BW*INC-1:0]   shreg, shreg_n;
    logic [SELW-1:0]     sel_r, sel_n;
    logic [SELW-1:0]     cnt, cnt_n;
    logic                rd_r, rd_n;
    logic [BW-1:0]       res_r, res_n;

`ifdef OPERATION_I_SEL_CHECK_EN
    logic                err_r, err_n;
    logic                sel_oor;

    assign sel_oor = ({1'b0, bus.SEL} >= (SELW+1)'(INC));
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
            shreg <= '0;
            sel_r <= '0;
            cnt   <= '0;
            rd_r  <= 1'b0;
            res_r <= '0;
`ifdef OPERATION_I_SEL_CHECK_EN
            err_r <= 1'b0;
`endif
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            sel_r <= sel_n;
            cnt   <= cnt_n;
            rd_r  <= rd_n;
            res_r <= res_n;
`ifdef OPERATION_I_SEL_CHECK_EN
            err_r <= err_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        sel_n   = sel_r;
        cnt_n   = cnt;
        rd_n    = rd_r;
        res_n   = res_r;
`ifdef OPERATION_I_SEL_CHECK_EN
        err_n   = err_r;
`endif
        case (state)
            S_IDLE: begin
                if (bus.ST) begin
                    shreg_n = bus.IN;
                    sel_n   = bus.SEL;
                    cnt_n   = '0;
                    rd_n    = 1'b0;
`ifdef OPERATION_I_SEL_CHECK_EN
                    if (sel_oor) begin
                        state_n = S_DONE;
                        res_n   = '0;
                        err_n   = 1'b1;
                        rd_n    = 1'b1;
                    end else begin
                        state_n = S_SCAN;
                        err_n   = 1'b0;
                    end
`else
                    state_n = S_SCAN;
`endif
                end
            end
            S_SCAN: begin
                // Word 0 sits at the head; every miss pulls the next word down and fills zeros on top,
                // so out-of-range selects land on zero words.
                if (cnt == sel_r) begin
                    res_n   = shreg[BW-1:0];
                    rd_n    = 1'b1;
                    state_n = S_DONE;
                end else begin
                    shreg_n = {{BW{1'b0}}, shreg[BW*INC-1:BW]};
                    cnt_n   = cnt + SELW'(1);
                end
            end
            S_DONE: begin
                if (!bus.ST) begin
                    state_n = S_IDLE;
                    rd_n    = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
                rd_n    = 1'b0;
            end
        endcase
    end

    assign bus.RD    = rd_r;
    assign bus.RES   = res_r;
`ifdef OPERATION_I_SEL_CHECK_EN
    assign bus.ERR   = err_r;
`endif
    assign dbg_state = state;

endmodule
